lfsr_rand_gen: RTL
==================

// Module: lfsr_rand_gen
// PURPOSE
//  Parametrised Fibonacci LFSR with lock-up guard, runtime seed load and a
//  bounded-range draw engine. Drives the game's random picks (mole index,
//  delay slot): game FSM pulses req with a limit, gets one value in [0,limit).
//  Free-running advance (shiftEn) is kept for entropy between draws.
// PARAMETERS
//  WIDTH      16       LFSR state width (>=4)
//  TAPS       16'hB400 feedback mask; bit i set => state[i] in XOR feedback
//  SEED       16'hACE1 reset/recovery value, must be nonzero
//  OUT_W      4        draw width; candidate = state[OUT_W-1:0]
//  MAX_TRIES  8        rejection-sampling attempts before fallback (>=1)
// PORTS
//  clk           in   1        rising-edge clock
//  rst           in   1        synchronous, active-high reset
//  shiftEn       in   1        advance LFSR one step (idle entropy)
//  seed_load     in   1        load seed_in into state this edge
//  seed_in       in   WIDTH    seed value; 0 => SEED loaded instead
//  req           in   1        draw request, sampled only while !busy
//  limit         in   OUT_W    exclusive upper bound; 0 => full 2^OUT_W range
//  busy          out  1        draw in progress (DRAW state)
//  rnd_valid     out  1        one-cycle pulse, rnd_out valid
//  rnd_out       out  OUT_W    drawn value, held until next rnd_valid
//  rnd_fallback  out  1        with rnd_valid: tries exhausted, rnd_out=0
//  state_out     out  WIDTH    current LFSR state
// BEHAVIOUR
//  Reset: state=SEED, FSM=IDLE, busy=0, rnd_valid=0, rnd_out=0,
//   rnd_fallback=0, try counter=0, limit_q=0.
//  Step: next = {state[WIDTH-2:0], ^(state & TAPS)}.
//  State update priority per edge: rst > seed_load > (state==0 -> SEED)
//   > advance (shiftEn | FSM==DRAW) > hold. Zero state never persists >1 cycle.
//  FSM IDLE: req=1 -> latch limit_q=limit, tries=0, go DRAW (busy=1 next
//   cycle). State advances at this edge only if shiftEn.
//  FSM DRAW, each edge: cand = state[OUT_W-1:0] (pre-edge value); state
//   advances regardless of shiftEn.
//   accept if limit_q==0 or cand<limit_q -> rnd_out=cand, rnd_valid=1,
//    rnd_fallback=0, go IDLE.
//   else if tries==MAX_TRIES-1 -> rnd_out=0, rnd_valid=1, rnd_fallback=1,
//    go IDLE. else tries++, stay.
//  Latency: rnd_valid high in cycle after edge k (k=1..MAX_TRIES) past req edge.
//  rnd_valid/rnd_fallback are 1-cycle pulses; rnd_out holds between draws.
//  req while busy ignored (no queueing); req may re-assert in cycle rnd_valid=1
//   (FSM is IDLE then) and is accepted.
//  seed_load during DRAW: state reloaded, draw continues from new state, tries
//   and limit_q unchanged. seed_load+req same edge: both take effect.
//  rst mid-DRAW: draw aborted, no rnd_valid, all reset values restored.
//  Widths: compare is unsigned OUT_W; tries counter $clog2(MAX_TRIES)+1 bits.
// STRUCTURE
//  Package lfsr_pkg: FSM state typedef (IDLE, DRAW), default TAPS/SEED consts.
//  One sub-module lfsr_core (WIDTH,TAPS,SEED): step/load/lock-up guard,
//  exposes state; lfsr_rand_gen holds the draw FSM and output registers.
// TESTING (defaults unless noted)
//  rst, then shiftEn=1 one cycle -> state_out 16'hACE1 -> 16'h59C3.
//  seed_load=1, seed_in=0 -> state_out=16'hACE1; force state 0 -> SEED next.
//  from reset, req=1 limit=4, shiftEn=0 -> rnd_valid after edge 1, rnd_out=1.
//  one shiftEn, then req limit=3 -> cands 3,7,F,E,C,9,2; rnd_valid after
//   edge 7, rnd_out=2, rnd_fallback=0; busy high edges 1..7.
//  MAX_TRIES=4, from reset req limit=1 -> cands 1,3,7,F rejected; after
//   edge 4 rnd_valid=1, rnd_out=0, rnd_fallback=1.
//  rst asserted during DRAW -> no rnd_valid; req during busy -> ignored.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared types and default constants for the LFSR random-draw block.
package lfsr_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        DRAW = 1'b1
    } drawState_t;

    localparam logic [15:0] DEF_TAPS = 16'hB400;
    localparam logic [15:0] DEF_SEED = 16'hACE1;

endpackage

// File: rtl/lfsr_rand_gen_if.sv
// Draw request/response handshake between the game FSM and the random generator.
interface lfsr_rand_gen_if #(
    parameter int OUT_W = 4
);
    logic             req;
    logic [OUT_W-1:0] limit;
    logic             busy;
    logic             rnd_valid;
    logic [OUT_W-1:0] rnd_out;
    logic             rnd_fallback;

    modport master (
        output req, limit,
        input  busy, rnd_valid, rnd_out, rnd_fallback
    );

    modport slave (
        input  req, limit,
        output busy, rnd_valid, rnd_out, rnd_fallback
    );
endinterface

// File: rtl/lfsr_core.sv
// Fibonacci LFSR state register with seed load and lock-up recovery.
module lfsr_core #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = lfsr_pkg::DEF_TAPS,
    parameter logic [WIDTH-1:0] SEED  = lfsr_pkg::DEF_SEED
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] loadVal,
    input  logic             advance,
    output logic [WIDTH-1:0] state
);

    logic [WIDTH-1:0] stepVal;

    assign stepVal = {state[WIDTH-2:0], ^(state & TAPS)};

    // A zero load would lock the register, so it is replaced by SEED.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SEED;
        end else if (load) begin
            state <= (loadVal == '0) ? SEED : loadVal;
        end else if (state == '0) begin
            state <= SEED;
        end else if (advance) begin
            state <= stepVal;
        end
    end

endmodule

// File: rtl/lfsr_rand_gen.sv
// Random generator top: LFSR plus a rejection-sampling draw FSM producing values in [0,limit).
//
// state | meaning
// IDLE  | waiting for req; LFSR advances only on shiftEn
// DRAW  | testing one candidate per edge; LFSR advances every edge
module lfsr_rand_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] TAPS      = DEF_TAPS,
    parameter logic [WIDTH-1:0] SEED      = DEF_SEED,
    parameter int               OUT_W     = 4,
    parameter int               MAX_TRIES = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               shiftEn,
    input  logic               seed_load,
    input  logic [WIDTH-1:0]   seed_in,
    output logic [WIDTH-1:0]   state_out,
    lfsr_rand_gen_if.slave     draw
);

    localparam int            TRY_W    = $clog2(MAX_TRIES) + 1;
    localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);

    drawState_t       curState, nxtState;
    logic [TRY_W-1:0] tries, triesNxt;
    logic [OUT_W-1:0] limitQ, limitNxt;
    logic [OUT_W-1:0] rndOutNxt;
    logic             validNxt, fallbackNxt;
    logic [OUT_W-1:0] cand;
    logic [WIDTH-1:0] lfsrState;

    lfsr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .load    (seed_load),
        .loadVal (seed_in),
        .advance (shiftEn | (curState == DRAW)),
        .state   (lfsrState)
    );

    assign state_out = lfsrState;
    assign cand      = lfsrState[OUT_W-1:0];
    assign draw.busy = (curState == DRAW);

    always_ff @(posedge clk) begin
        if (rst) begin
            curState          <= IDLE;
            tries             <= '0;
            limitQ            <= '0;
            draw.rnd_out      <= '0;
            draw.rnd_valid    <= 1'b0;
            draw.rnd_fallback <= 1'b0;
        end else begin
            curState          <= nxtState;
            tries             <= triesNxt;
            limitQ            <= limitNxt;
            draw.rnd_out      <= rndOutNxt;
            draw.rnd_valid    <= validNxt;
            draw.rnd_fallback <= fallbackNxt;
        end
    end

    always_comb begin
        nxtState    = curState;
        triesNxt    = tries;
        limitNxt    = limitQ;
        rndOutNxt   = draw.rnd_out;
        validNxt    = 1'b0;
        fallbackNxt = 1'b0;
        unique case (curState)
            IDLE: begin
                if (draw.req) begin
                    limitNxt = draw.limit;
                    triesNxt = '0;
                    nxtState = DRAW;
                end
            end
            DRAW: begin
                // limit of zero means the whole OUT_W range is acceptable
                if ((limitQ == '0) || (cand < limitQ)) begin
                    rndOutNxt = cand;
                    validNxt  = 1'b1;
                    nxtState  = IDLE;
                end else if (tries == LAST_TRY) begin
                    rndOutNxt   = '0;
                    validNxt    = 1'b1;
                    fallbackNxt = 1'b1;
                    nxtState    = IDLE;
                end else begin
                    triesNxt = tries + 1'b1;
                end
            end
            default: nxtState = IDLE;
        endcase
    end

endmodule
